// File: rtl/frac_clk_div_pkg.sv
// Shared definitions for the fractional clock divider: FSM states, config reset
// defaults and the config legality check.
package frac_clk_div_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_N = 32'd2;
  localparam int unsigned RST_M = 32'd0;
  localparam int unsigned RST_D = 32'd1;

  // A config is legal when N reaches the minimum, D is non-zero and M/D is a proper fraction.
  function automatic logic cfg_ok(input int unsigned n, input int unsigned m,
                                  input int unsigned d);
    return (n >= MIN_N) && (d != 32'd0) && (m < d);
  endfunction

endpackage

// File: rtl/frac_div_acc.sv
// Phase accumulator for the fractional divider; carry says the period that starts
// now is one cycle longer than N.
module frac_div_acc
  import frac_clk_div_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  input  logic [AW-1:0] m,
  input  logic [AW-1:0] d,
  output logic          carry
);

  logic [AW-1:0] acc;
  logic [AW:0]   sum;
  logic [AW:0]   wrap;

  // The sum is one bit wider than the accumulator so acc + M never overflows.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, m};
    wrap  = sum - {1'b0, d};
    carry = (sum >= {1'b0, d});
  end

  // Accumulator update once per period start; an abort clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= {AW{1'b0}};
    end else if (clr) begin
      acc <= {AW{1'b0}};
    end else if (step) begin
      acc <= carry ? wrap[AW-1:0] : sum[AW-1:0];
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/frac_clk_div.sv
// Fractional clock divider: average period N + M/D clocks, each period N or N+1.
// Define FRAC_CLK_DIV_DUTY50_EN to shape div_clk to roughly 50% duty.
module frac_clk_div
  import frac_clk_div_pkg::*;
#(
  parameter int CW    = 8,
  parameter int AW    = 8,
  parameter int DEF_N = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_load,
  input  logic [CW-1:0] div_int,
  input  logic [AW-1:0] frac_num,
  input  logic [AW-1:0] frac_den,
  output logic          div_pulse,
  output logic          div_clk,
  output logic          cfg_ack,
  output logic          cfg_err
);

  state_t        state, state_nx;
  logic [CW-1:0] cur_n, pend_n, eff_n;
  logic [AW-1:0] cur_m, pend_m, eff_m;
  logic [AW-1:0] cur_d, pend_d, eff_d;
  logic          pend;
  logic [CW:0]   cnt, cnt_nx, tgt, tgt_nx;
  logic          load_ok, start, bnd, abort, apply, carry;

  frac_div_acc #(.AW(AW)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort),
    .step  (start | bnd),
    .m     (eff_m),
    .d     (eff_d),
    .carry (carry)
  );

  // Next-state, period boundary detection and effective-config selection.
  always_comb begin
    load_ok  = cfg_load && cfg_ok(32'(div_int), 32'(frac_num), 32'(frac_den));
    state_nx = state;
    start    = 1'b0;
    bnd      = 1'b0;
    abort    = 1'b0;
    eff_n    = cur_n;
    eff_m    = cur_m;
    eff_d    = cur_d;
    // A load landing on the boundary edge wins over an older pending value.
    if (load_ok) begin
      eff_n = div_int;
      eff_m = frac_num;
      eff_d = frac_den;
    end else if (pend) begin
      eff_n = pend_n;
      eff_m = pend_m;
      eff_d = pend_d;
    end else begin
      eff_n = cur_n;
    end
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nx = ST_RUN;
          start    = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_nx = ST_IDLE;
          abort    = 1'b1;
        end else if (cnt == tgt) begin
          bnd = 1'b1;
        end else begin
          bnd = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    apply  = (load_ok || pend) && ((state == ST_IDLE) || abort || bnd);
    tgt_nx = {1'b0, eff_n} + {{CW{1'b0}}, carry};
    if (start || bnd) begin
      cnt_nx = {{CW{1'b0}}, 1'b1};
    end else if (state_nx == ST_IDLE) begin
      cnt_nx = {(CW+1){1'b0}};
    end else begin
      cnt_nx = cnt + {{CW{1'b0}}, 1'b1};
    end
  end

  // FSM, period counter, outputs and config shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= {(CW+1){1'b0}};
      tgt       <= (CW+1)'(DEF_N);
      cur_n     <= CW'(DEF_N);
      cur_m     <= AW'(RST_M);
      cur_d     <= AW'(RST_D);
      pend      <= 1'b0;
      pend_n    <= CW'(DEF_N);
      pend_m    <= AW'(RST_M);
      pend_d    <= AW'(RST_D);
      div_pulse <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      div_pulse <= bnd;
      cfg_ack   <= apply;
      if (start || bnd) begin
        tgt <= tgt_nx;
      end else begin
        tgt <= tgt;
      end
      if (apply) begin
        cur_n <= eff_n;
        cur_m <= eff_m;
        cur_d <= eff_d;
        pend  <= 1'b0;
      end else if (load_ok) begin
        pend_n <= div_int;
        pend_m <= frac_num;
        pend_d <= frac_den;
        pend   <= 1'b1;
      end else begin
        pend <= pend;
      end
      if (cfg_load) begin
        cfg_err <= !load_ok;
      end else begin
        cfg_err <= cfg_err;
      end
    end
  end

`ifdef FRAC_CLK_DIV_DUTY50_EN
  logic duty;

  // High from the boundary pulse through the first floor(P/2) cycles of the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= 1'b0;
    end else if (bnd) begin
      duty <= 1'b1;
    end else if (state_nx != ST_RUN) begin
      duty <= 1'b0;
    end else if (cnt_nx > (tgt >> 1)) begin
      duty <= 1'b0;
    end else begin
      duty <= duty;
    end
  end

  assign div_clk = duty;
`else
  assign div_clk = div_pulse;
`endif

endmodule

// File: tb/tb_frac_clk_div.sv
// Directed self-checking bench for frac_clk_div; periods are measured in clk
// cycles between consecutive div_pulse highs.
module tb_frac_clk_div;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] div_int = 8'd0;
  logic [7:0] frac_num = 8'd0;
  logic [7:0] frac_den = 8'd0;
  logic       div_pulse, div_clk, cfg_ack, cfg_err;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  frac_clk_div #(.CW(8), .AW(8), .DEF_N(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_load  (cfg_load),
    .div_int   (div_int),
    .frac_num  (frac_num),
    .frac_den  (frac_den),
    .div_pulse (div_pulse),
    .div_clk   (div_clk),
    .cfg_ack   (cfg_ack),
    .cfg_err   (cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the next div_pulse high; -1 when none arrives within budget.
  task automatic wait_pulse(output int n);
    n = 0;
    while (n < 60) begin
      tick();
      n++;
      if (div_pulse) break;
    end
    if (!div_pulse) n = -1;
  endtask

  task automatic do_load(input int n, input int m, input int d);
    cfg_load = 1'b1;
    div_int  = 8'(n);
    frac_num = 8'(m);
    frac_den = 8'(d);
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic restart_with(input int n, input int m, input int d);
    en = 1'b0;
    tick();
    do_load(n, m, d);
    en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (div_pulse !== 1'b0) begin fails++; $display("FAIL rst_pulse: got %b expected 0", div_pulse); end
    tests++; if (div_clk !== 1'b0) begin fails++; $display("FAIL rst_clk: got %b expected 0", div_clk); end
    tests++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b expected 0", cfg_ack); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", cfg_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_integer();
    int p;
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_pulse(p);
      tests++; if (p !== 5) begin fails++; $display("FAIL int_period[%0d]: got %0d expected 5", i, p); end
    end
    tick();
    tests++; if (div_pulse !== 1'b0) begin fails++; $display("FAIL pulse_width: got %b expected 0", div_pulse); end
`ifndef FRAC_CLK_DIV_DUTY50_EN
    begin
      int bad = 0;
      for (int i = 0; i < 12; i++) begin
        if (div_clk !== div_pulse) bad++;
        tick();
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL clk_eq_pulse: got %0d differing cycles expected 0", bad); end
    end
`endif
  endtask

  task automatic test_frac();
    int p, sum;
    int exp_p[8] = '{5, 5, 6, 5, 5, 6, 5, 6};
    en = 1'b0;
    tick();
    do_load(5, 3, 8);
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL idle_ack: got %b expected 1", cfg_ack); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL idle_err: got %b expected 0", cfg_err); end
    en = 1'b1;
    tick();
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      wait_pulse(p);
      sum += p;
      tests++; if (p !== exp_p[i]) begin fails++; $display("FAIL frac_period[%0d]: got %0d expected %0d", i, p, exp_p[i]); end
    end
    tests++; if (sum !== 43) begin fails++; $display("FAIL frac_sum: got %0d expected 43", sum); end
  endtask

  task automatic test_reject();
    int p;
    restart_with(5, 0, 1);
    wait_pulse(p);
    tests++; if (p !== 5) begin fails++; $display("FAIL rej_first: got %0d expected 5", p); end
    do_load(1, 0, 1);
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL rej_n1: got %b expected 1", cfg_err); end
    do_load(5, 0, 0);
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL rej_d0: got %b expected 1", cfg_err); end
    do_load(4, 4, 4);
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL rej_meqd: got %b expected 1", cfg_err); end
    tests++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL rej_ack: got %b expected 0", cfg_ack); end
    wait_pulse(p);
    tests++; if (p !== 2) begin fails++; $display("FAIL rej_rem: got %0d expected 2", p); end
    wait_pulse(p);
    tests++; if (p !== 5) begin fails++; $display("FAIL rej_period: got %0d expected 5", p); end
    do_load(3, 0, 1);
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL ok_err: got %b expected 0", cfg_err); end
    tests++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL ok_early_ack: got %b expected 0", cfg_ack); end
    wait_pulse(p);
    tests++; if (p !== 4) begin fails++; $display("FAIL ok_rem: got %0d expected 4", p); end
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL ok_ack: got %b expected 1", cfg_ack); end
    wait_pulse(p);
    tests++; if (p !== 3) begin fails++; $display("FAIL ok_period: got %0d expected 3", p); end
    tests++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL ok_ack_once: got %b expected 0", cfg_ack); end
  endtask

  task automatic test_mid_change();
    int p;
    restart_with(4, 0, 1);
    wait_pulse(p);
    tests++; if (p !== 4) begin fails++; $display("FAIL mid_first: got %0d expected 4", p); end
    do_load(7, 0, 1);
    wait_pulse(p);
    tests++; if (p !== 3) begin fails++; $display("FAIL mid_rem: got %0d expected 3", p); end
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL mid_ack: got %b expected 1", cfg_ack); end
    for (int i = 0; i < 2; i++) begin
      wait_pulse(p);
      tests++; if (p !== 7) begin fails++; $display("FAIL mid_new[%0d]: got %0d expected 7", i, p); end
    end
  endtask

  task automatic test_back_to_back();
    int p;
    repeat (6) tick();
    do_load(3, 0, 1);
    tests++; if (div_pulse !== 1'b1) begin fails++; $display("FAIL coin_pulse: got %b expected 1", div_pulse); end
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL coin_ack: got %b expected 1", cfg_ack); end
    wait_pulse(p);
    tests++; if (p !== 3) begin fails++; $display("FAIL coin_period: got %0d expected 3", p); end
    do_load(6, 0, 1);
    do_load(4, 0, 1);
    wait_pulse(p);
    tests++; if (p !== 1) begin fails++; $display("FAIL ovw_rem: got %0d expected 1", p); end
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL ovw_ack: got %b expected 1", cfg_ack); end
    wait_pulse(p);
    tests++; if (p !== 4) begin fails++; $display("FAIL ovw_period: got %0d expected 4", p); end
  endtask

  task automatic test_abort();
    int p, seen;
    int exp_p[3] = '{5, 5, 6};
    restart_with(5, 3, 8);
    wait_pulse(p);
    wait_pulse(p);
    tick();
    tick();
    en = 1'b0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (div_pulse) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_pulses: got %0d expected 0", seen); end
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      wait_pulse(p);
      tests++; if (p !== exp_p[i]) begin fails++; $display("FAIL abort_period[%0d]: got %0d expected %0d", i, p, exp_p[i]); end
    end
  endtask

  task automatic test_rst_mid();
    int p;
    restart_with(3, 0, 1);
    do_load(1, 0, 1);
    wait_pulse(p);
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL rmid_err_pre: got %b expected 1", cfg_err); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (div_pulse !== 1'b0) begin fails++; $display("FAIL rmid_pulse: got %b expected 0", div_pulse); end
    tests++; if (div_clk !== 1'b0) begin fails++; $display("FAIL rmid_clk: got %b expected 0", div_clk); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL rmid_err: got %b expected 0", cfg_err); end
    tick();
    rst = 1'b0;
    tick();
    wait_pulse(p);
    tests++; if (p !== 5) begin fails++; $display("FAIL rmid_defn: got %0d expected 5", p); end
  endtask

`ifdef FRAC_CLK_DIV_DUTY50_EN
  task automatic test_duty();
    int p, n, hi;
    int exp_n[4] = '{6, 5, 6, 5};
    restart_with(5, 1, 2);
    wait_pulse(p);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      hi = 0;
      while (n < 60) begin
        if (div_clk) hi++;
        tick();
        n++;
        if (div_pulse) break;
      end
      tests++; if (n !== exp_n[i]) begin fails++; $display("FAIL duty_period[%0d]: got %0d expected %0d", i, n, exp_n[i]); end
      tests++; if (hi !== exp_n[i] / 2) begin fails++; $display("FAIL duty_high[%0d]: got %0d expected %0d", i, hi, exp_n[i] / 2); end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_integer();
    test_frac();
    test_reject();
    test_mid_change();
    test_back_to_back();
    test_abort();
    test_rst_mid();
`ifdef FRAC_CLK_DIV_DUTY50_EN
    test_duty();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
